// File: rtl/key_event.sv
// Key-event decoder: turns a debounced key level into single-cycle press, release,
// click, double-click, long-press and auto-repeat pulses. All timing is in clk cycles.
module key_event #(
    parameter logic        PRESS_LEVEL = 1'b1,
    parameter int unsigned LONG_CNT    = 32'd50_000_000,
    parameter int unsigned DBL_CNT     = 32'd15_000_000,
    parameter int unsigned REPEAT_CNT  = 32'd5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic key_state_o,
    output logic press_o,
    output logic release_o,
    output logic click_o,
    output logic dbl_click_o,
    output logic long_o,
    output logic repeat_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_t;

    localparam logic [31:0] LONG_LAST = LONG_CNT - 32'd1;
    localparam logic [31:0] DBL_LAST  = DBL_CNT - 32'd1;
    localparam logic [31:0] REP_LAST  = REPEAT_CNT - 32'd1;
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    state_t      state_r, state_s;
    logic [31:0] cnt_r, cnt_s, cnt_inc_s;
    logic        key_q_r;
    logic        pressed_s, rise_s, fall_s;
    logic        press_s, release_s, click_s, dbl_s, long_s, repeat_s;
    logic        press_r, release_r, click_r, dbl_r, long_r, repeat_r;

    assign pressed_s = (key_i == PRESS_LEVEL);
    assign rise_s    = pressed_s & ~key_q_r;
    assign fall_s    = ~pressed_s & key_q_r;
    // Saturating increment keeps the counter from wrapping back into a match window
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 32'd1;

    // Next-state, counter and event-pulse decode
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        click_s   = 1'b0;
        dbl_s     = 1'b0;
        long_s    = 1'b0;
        repeat_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_s = ST_PRESS1;
                    cnt_s   = 32'd0;
                    press_s = 1'b1;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_PRESS1: begin
                if (fall_s) begin
                    state_s   = ST_WAIT2;
                    cnt_s     = 32'd0;
                    release_s = 1'b1;
                end else if (cnt_r == LONG_LAST) begin
                    state_s = ST_LONG;
                    cnt_s   = 32'd0;
                    long_s  = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_WAIT2: begin
                // A rise on the timeout edge still counts as the second tap
                if (rise_s) begin
                    state_s = ST_PRESS2;
                    cnt_s   = 32'd0;
                    press_s = 1'b1;
                end else if (cnt_r == DBL_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = 32'd0;
                    click_s = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_PRESS2: begin
                if (fall_s) begin
                    state_s   = ST_IDLE;
                    cnt_s     = 32'd0;
                    release_s = 1'b1;
                    dbl_s     = 1'b1;
                end else if (cnt_r == LONG_LAST) begin
                    state_s = ST_LONG;
                    cnt_s   = 32'd0;
                    click_s = 1'b1;
                    long_s  = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_LONG: begin
                if (fall_s) begin
                    state_s   = ST_IDLE;
                    cnt_s     = 32'd0;
                    release_s = 1'b1;
                end else if (cnt_r == REP_LAST) begin
                    cnt_s    = 32'd0;
                    repeat_s = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 32'd0;
            end
        endcase
    end

    // State, counter, edge history and registered event outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 32'd0;
            key_q_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            click_r   <= 1'b0;
            dbl_r     <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            key_q_r   <= pressed_s;
            press_r   <= press_s;
            release_r <= release_s;
            click_r   <= click_s;
            dbl_r     <= dbl_s;
            long_r    <= long_s;
            repeat_r  <= repeat_s;
        end
    end

    // key_q_r already holds the pressed flag with one cycle of latency
    assign key_state_o = key_q_r;
    assign press_o     = press_r;
    assign release_o   = release_r;
    assign click_o     = click_r;
    assign dbl_click_o = dbl_r;
    assign long_o      = long_r;
    assign repeat_o    = repeat_r;

endmodule
